// File: rtl/lsu_mem_master.sv
// lsu_mem_master: bounds-checked load/store initiator between the core memory stage and a word memory.
// Optional statistics counters are compiled in when LSU_MEM_MASTER_STATS_EN is defined.
module lsu_mem_master #(
    parameter int MEM_WORDS   = 64,
    parameter int WAIT_CYCLES = 1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_write,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic        resp_valid,
    output logic [31:0] resp_rdata,
    output logic        resp_err,
    output logic        mem_read,
    output logic        mem_write,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    input  logic [31:0] mem_rdata,
    output logic        busy
`ifdef LSU_MEM_MASTER_STATS_EN
    ,
    output logic [15:0] load_count,
    output logic [15:0] store_count,
    output logic [15:0] err_count
`endif
);

    typedef enum logic [1:0] {IDLE, ACCESS, RESP} state_t;

    state_t      state;
    logic        wr;
    logic [31:0] wait_cnt;
    logic        bad;
    logic        done;

    // Request rejection and access completion decode.
    always_comb begin
        bad  = (|req_addr[1:0]) || ({2'b00, req_addr[31:2]} >= 32'(MEM_WORDS));
        done = (state == ACCESS) && (wr || wait_cnt == 32'd0);
    end

    // Transaction FSM; every output is a register updated on the state transitions.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= IDLE;
            wr         <= 1'b0;
            wait_cnt   <= 32'd0;
            req_ready  <= 1'b1;
            resp_valid <= 1'b0;
            resp_rdata <= 32'd0;
            resp_err   <= 1'b0;
            mem_read   <= 1'b0;
            mem_write  <= 1'b0;
            mem_addr   <= 32'd0;
            mem_wdata  <= 32'd0;
            busy       <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (req_valid) begin
                        req_ready <= 1'b0;
                        busy      <= 1'b1;
                        wr        <= req_write;
                        if (bad) begin
                            state      <= RESP;
                            resp_valid <= 1'b1;
                            resp_err   <= 1'b1;
                            resp_rdata <= 32'd0;
                        end else begin
                            state     <= ACCESS;
                            mem_addr  <= {2'b00, req_addr[31:2]};
                            mem_write <= req_write;
                            mem_read  <= !req_write;
                            mem_wdata <= req_write ? req_wdata : 32'd0;
                            wait_cnt  <= 32'(WAIT_CYCLES - 1);
                        end
                    end
                end
                ACCESS: begin
                    if (done) begin
                        state      <= RESP;
                        resp_valid <= 1'b1;
                        resp_rdata <= wr ? 32'd0 : mem_rdata;
                        mem_read   <= 1'b0;
                        mem_write  <= 1'b0;
                        mem_addr   <= 32'd0;
                        mem_wdata  <= 32'd0;
                    end else begin
                        wait_cnt <= wait_cnt - 32'd1;
                    end
                end
                default: begin
                    state      <= IDLE;
                    resp_valid <= 1'b0;
                    resp_err   <= 1'b0;
                    resp_rdata <= 32'd0;
                    req_ready  <= 1'b1;
                    busy       <= 1'b0;
                end
            endcase
        end
    end

`ifdef LSU_MEM_MASTER_STATS_EN
    // Saturating completion counters, bumped on the edge that raises the response pulse.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            load_count  <= 16'd0;
            store_count <= 16'd0;
            err_count   <= 16'd0;
        end else begin
            if (state == IDLE && req_valid && bad && err_count != 16'hFFFF)
                err_count <= err_count + 16'd1;
            if (done && wr && store_count != 16'hFFFF)
                store_count <= store_count + 16'd1;
            if (done && !wr && load_count != 16'hFFFF)
                load_count <= load_count + 16'd1;
        end
    end
`endif

endmodule

// File: tb/tb_lsu_mem_master.sv
// tb_lsu_mem_master: table-driven and directed checks of the load/store initiator against a word memory model.
module tb_lsu_mem_master;

    localparam int WAIT = 1;

    logic        clk = 1'b0;
    logic        rst;
    logic        req_valid;
    logic        req_ready;
    logic        req_write;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic        resp_valid;
    logic [31:0] resp_rdata;
    logic        resp_err;
    logic        mem_read;
    logic        mem_write;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [31:0] mem_rdata;
    logic        busy;
`ifdef LSU_MEM_MASTER_STATS_EN
    logic [15:0] load_count;
    logic [15:0] store_count;
    logic [15:0] err_count;
`endif

    logic [31:0] mem [64];

    int n_chk = 0;
    int n_fail = 0;

    typedef struct {
        logic        write;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic        err;
        logic [31:0] rdata;
        logic [31:0] maddr;
    } vec_t;

    vec_t vecs [11];

    always #5 clk = ~clk;

    assign mem_rdata = mem[mem_addr[5:0]];

    always @(negedge clk) if (mem_write) mem[mem_addr[5:0]] <= mem_wdata;

    lsu_mem_master #(.MEM_WORDS(64), .WAIT_CYCLES(WAIT)) dut (
        .clk(clk),
        .rst(rst),
        .req_valid(req_valid),
        .req_ready(req_ready),
        .req_write(req_write),
        .req_addr(req_addr),
        .req_wdata(req_wdata),
        .resp_valid(resp_valid),
        .resp_rdata(resp_rdata),
        .resp_err(resp_err),
        .mem_read(mem_read),
        .mem_write(mem_write),
        .mem_addr(mem_addr),
        .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata),
        .busy(busy)
`ifdef LSU_MEM_MASTER_STATS_EN
        ,
        .load_count(load_count),
        .store_count(store_count),
        .err_count(err_count)
`endif
    );

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic chk_reset_outputs(input string tag);
        chk({tag, "_req_ready"}, 32'(req_ready), 32'd1);
        chk({tag, "_resp_valid"}, 32'(resp_valid), 32'd0);
        chk({tag, "_resp_rdata"}, resp_rdata, 32'd0);
        chk({tag, "_resp_err"}, 32'(resp_err), 32'd0);
        chk({tag, "_mem_read"}, 32'(mem_read), 32'd0);
        chk({tag, "_mem_write"}, 32'(mem_write), 32'd0);
        chk({tag, "_mem_addr"}, mem_addr, 32'd0);
        chk({tag, "_mem_wdata"}, mem_wdata, 32'd0);
        chk({tag, "_busy"}, 32'(busy), 32'd0);
`ifdef LSU_MEM_MASTER_STATS_EN
        chk({tag, "_load_count"}, 32'(load_count), 32'd0);
        chk({tag, "_store_count"}, 32'(store_count), 32'd0);
        chk({tag, "_err_count"}, 32'(err_count), 32'd0);
`endif
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int exp_loads;
        int exp_stores;
        int exp_errs;
        int lat;
        int rd_cyc;
        int wr_cyc;
        int both;
        int exp_lat;
        int acc;
        int resps;
        int bad_ready;
        int bad_data;
        logic [31:0] seen_addr;
        logic [31:0] seen_wdata;

        vecs[0]  = '{1'b1, 32'h0000000C, 32'hDEADBEEF, 1'b0, 32'h00000000, 32'd3};
        vecs[1]  = '{1'b0, 32'h0000000C, 32'h00000000, 1'b0, 32'hDEADBEEF, 32'd3};
        vecs[2]  = '{1'b0, 32'h00000006, 32'h00000000, 1'b1, 32'h00000000, 32'd0};
        vecs[3]  = '{1'b1, 32'h000000FC, 32'h12345678, 1'b0, 32'h00000000, 32'd63};
        vecs[4]  = '{1'b1, 32'h00000100, 32'hBADBAD00, 1'b1, 32'h00000000, 32'd0};
        vecs[5]  = '{1'b0, 32'h000000FC, 32'h00000000, 1'b0, 32'h12345678, 32'd63};
        vecs[6]  = '{1'b0, 32'hFFFFFFFC, 32'h00000000, 1'b1, 32'h00000000, 32'd0};
        vecs[7]  = '{1'b1, 32'h00000000, 32'hA5A5A5A5, 1'b0, 32'h00000000, 32'd0};
        vecs[8]  = '{1'b1, 32'h00000002, 32'h11111111, 1'b1, 32'h00000000, 32'd0};
        vecs[9]  = '{1'b0, 32'h00000000, 32'h00000000, 1'b0, 32'hA5A5A5A5, 32'd0};
        vecs[10] = '{1'b0, 32'h80000000, 32'h00000000, 1'b1, 32'h00000000, 32'd0};

        exp_loads = 0;
        exp_stores = 0;
        exp_errs = 0;

        rst = 1'b1;
        req_valid = 1'b0;
        req_write = 1'b0;
        req_addr = 32'd0;
        req_wdata = 32'd0;
        repeat (2) @(posedge clk);
        #1 chk_reset_outputs("por");
        @(negedge clk) rst = 1'b0;

        for (int i = 0; i < 11; i++) begin
            @(negedge clk);
            chk($sformatf("v%0d_ready_idle", i), 32'(req_ready), 32'd1);
            req_valid = 1'b1;
            req_write = vecs[i].write;
            req_addr = vecs[i].addr;
            req_wdata = vecs[i].wdata;
            @(posedge clk);
            #1 req_valid = 1'b0;
            lat = 1;
            rd_cyc = 0;
            wr_cyc = 0;
            both = 0;
            seen_addr = 32'd0;
            seen_wdata = 32'd0;
            while (!resp_valid && lat < 20) begin
                if (mem_read) begin
                    rd_cyc++;
                    seen_addr = mem_addr;
                end
                if (mem_write) begin
                    wr_cyc++;
                    seen_addr = mem_addr;
                    seen_wdata = mem_wdata;
                end
                if (mem_read && mem_write) both++;
                @(posedge clk);
                #1 lat++;
            end
            exp_lat = vecs[i].err ? 1 : (vecs[i].write ? 2 : WAIT + 1);
            chk($sformatf("v%0d_latency", i), 32'(lat), 32'(exp_lat));
            chk($sformatf("v%0d_resp_err", i), 32'(resp_err), 32'(vecs[i].err));
            chk($sformatf("v%0d_resp_rdata", i), resp_rdata, vecs[i].rdata);
            chk($sformatf("v%0d_read_cycles", i), 32'(rd_cyc), (!vecs[i].err && !vecs[i].write) ? 32'(WAIT) : 32'd0);
            chk($sformatf("v%0d_write_cycles", i), 32'(wr_cyc), (!vecs[i].err && vecs[i].write) ? 32'd1 : 32'd0);
            chk($sformatf("v%0d_mem_addr", i), seen_addr, vecs[i].maddr);
            chk($sformatf("v%0d_mem_wdata", i), seen_wdata, (!vecs[i].err && vecs[i].write) ? vecs[i].wdata : 32'd0);
            chk($sformatf("v%0d_strobe_overlap", i), 32'(both), 32'd0);
            chk($sformatf("v%0d_strobes_off_resp", i), {30'd0, mem_read, mem_write}, 32'd0);
            chk($sformatf("v%0d_ready_in_resp", i), 32'(req_ready), 32'd0);
            @(posedge clk);
            #1;
            chk($sformatf("v%0d_pulse_end", i), {29'd0, resp_valid, resp_err, busy}, 32'd0);
            chk($sformatf("v%0d_rdata_clear", i), resp_rdata, 32'd0);
            chk($sformatf("v%0d_ready_back", i), 32'(req_ready), 32'd1);
            if (vecs[i].err) exp_errs++;
            else if (vecs[i].write) exp_stores++;
            else exp_loads++;
        end

        @(negedge clk);
        req_valid = 1'b1;
        req_write = 1'b0;
        req_addr = 32'h0000000C;
        acc = 0;
        resps = 0;
        bad_ready = 0;
        bad_data = 0;
        for (int c = 0; c < 14; c++) begin
            if (resp_valid) begin
                resps++;
                if (resp_rdata !== 32'hDEADBEEF || resp_err) bad_data++;
            end
            if (req_ready == busy) bad_ready++;
            if (req_valid && acc == 3) req_valid = 1'b0;
            else if (req_ready && req_valid) acc++;
            @(negedge clk);
        end
        chk("hold_accepts", 32'(acc), 32'd3);
        chk("hold_resp_pulses", 32'(resps), 32'd3);
        chk("hold_ready_vs_busy", 32'(bad_ready), 32'd0);
        chk("hold_resp_data", 32'(bad_data), 32'd0);
        exp_loads += 3;

`ifdef LSU_MEM_MASTER_STATS_EN
        chk("stats_load_count", 32'(load_count), 32'(exp_loads));
        chk("stats_store_count", 32'(store_count), 32'(exp_stores));
        chk("stats_err_count", 32'(err_count), 32'(exp_errs));
`endif

        @(negedge clk);
        req_valid = 1'b1;
        req_write = 1'b0;
        req_addr = 32'h00000010;
        @(posedge clk);
        #1 req_valid = 1'b0;
        chk("midrst_read_strobe", 32'(mem_read), 32'd1);
        #1 rst = 1'b1;
        #1 chk_reset_outputs("midrst");
        @(negedge clk) rst = 1'b0;
        resps = 0;
        for (int c = 0; c < 4; c++) begin
            @(posedge clk);
            #1 if (resp_valid) resps++;
        end
        chk("midrst_no_resp", 32'(resps), 32'd0);
        chk("midrst_ready_after", 32'(req_ready), 32'd1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/lsu_mem_master.md
Name: lsu_mem_master

Overview:
- Load/store initiator sitting between the core's memory-stage control and the 64-word data memory.
- Accepts one byte-addressed word request at a time over a valid/ready handshake. Checks alignment and range, then drives the memory strobes (read, write, word address, write data).
- Returns the result over a one-cycle response pulse, turning the core's combinational memory access into a multi-cycle, bounds-checked transaction.

Parameters:
- MEM_WORDS, 64, number of 32-bit words in the target memory; legal word index is 0..MEM_WORDS-1.
- WAIT_CYCLES, 1, number of cycles read is held before data is sampled; must be ≥1.

Ports:
- clk  in  1  system clock; all state changes on posedge.
- rst  in  1  reset, asynchronous, active-high.
- req_valid  in  1  core request present.
- req_ready  out  1  block can accept a request.
- req_write  in  1  1 = store, 0 = load.
- req_addr  in  32  byte address.
- req_wdata  in  32  store data.
- resp_valid  out  1  one-cycle completion pulse.
- resp_rdata  out  32  load data; 0 for stores and errors.
- resp_err  out  1  request rejected (misaligned or out of range); valid with resp_valid.
- mem_read  out  1  memory read strobe.
- mem_write  out  1  memory write strobe; memory commits on negedge clk.
- mem_addr  out  32  word index, zero-extended.
- mem_wdata  out  32  memory write data.
- mem_rdata  in  32  memory read data; combinational from memory.
- busy  out  1  high in any state other than IDLE.

Behaviour:
- Reset values, asynchronous: state IDLE; req_ready=1; resp_valid=0; resp_rdata=0; resp_err=0; mem_read=0; mem_write=0; mem_addr=0; mem_wdata=0; busy=0; wait counter=0.
- All outputs are registered; none are combinational from inputs.
- States are IDLE, ACCESS and RESP.
- IDLE:
  - req_ready=1.
  - On a posedge with req_valid=1, the request is accepted and req_write, req_addr and req_wdata are latched.
  - Error if req_addr[1:0]!=0 or req_addr[31:2]≥MEM_WORDS. On error: go to RESP with resp_err=1 and resp_rdata=0. No memory strobe is ever asserted.
  - Otherwise go to ACCESS. mem_addr={2'b0,req_addr[31:2]}. A store sets mem_write=1 and mem_wdata=req_wdata. A load sets mem_read=1. The wait counter is loaded with WAIT_CYCLES-1.
- ACCESS, store:
  - Lasts exactly 1 cycle; the memory commits at the negedge inside it.
  - At the next posedge: mem_write=0, mem_wdata=0, mem_addr=0, resp_rdata=0; go to RESP.
- ACCESS, load:
  - mem_read is held while the counter is nonzero; the counter decrements each posedge.
  - At the posedge when the counter is 0: resp_rdata is captured from mem_rdata, mem_read=0, mem_addr=0; go to RESP.
- RESP:
  - resp_valid=1 for exactly one cycle, then return to IDLE.
  - resp_valid, resp_err and resp_rdata clear on the IDLE-entry edge.
- req_ready=0 in ACCESS and RESP. A req_valid asserted there is ignored and must be held by the core.
- Latency from accept edge to resp_valid high:
  - store: 2 cycles.
  - load: WAIT_CYCLES+1 cycles.
  - error: 1 cycle.
- Throughput: one request per (latency+1) cycles; no back-to-back acceptance.
- mem_read and mem_write are never high simultaneously.
- Boundaries:
  - Word index MEM_WORDS-1 (byte address 4*MEM_WORDS-4) is legal.
  - Byte address 4*MEM_WORDS is an error.
  - Address 0xFFFFFFFC is an error; no wrap-around.
- Reset mid-operation: all strobes drop immediately, any in-flight response is discarded, the FSM returns to IDLE, and no response pulse is produced.

Optional Feature:
- Macro LSU_MEM_MASTER_STATS_EN.
- When defined, three extra output ports are added:
  - load_count[15:0]: completed loads.
  - store_count[15:0]: completed stores.
  - err_count[15:0]: rejected requests.
- Each counter increments on the cycle its response pulse is issued and saturates at 16'hFFFF.
- All three reset to 0 on rst.
- When undefined, the ports and logic are absent and the behaviour is otherwise identical.

Test Plan:
- Reset: assert rst mid-run → all outputs take their reset values within the same cycle, and req_ready=1 after release.
- Aligned store then load, default WAIT_CYCLES=1:
  - Store req_addr=0x0000000C, req_wdata=0xDEADBEEF → mem_write pulse of 1 cycle with mem_addr=3, then resp_valid with resp_err=0.
  - Load 0x0000000C → mem_read pulse with mem_addr=3, then resp_rdata=0xDEADBEEF and resp_valid 2 cycles after accept.
- Misaligned load req_addr=0x00000006 → resp_err=1 and resp_rdata=0 one cycle after accept; mem_read and mem_write stay 0 throughout.
- Range edge:
  - Store to 0x000000FC → accepted, mem_addr=63.
  - Store to 0x00000100 → resp_err=1, memory untouched (a later load of 0xFC still returns its value).
- Handshake hold: keep req_valid high across 3 consecutive requests → each accepted only in IDLE, req_ready low during ACCESS and RESP, exactly 3 resp_valid pulses.
- Stats, with LSU_MEM_MASTER_STATS_EN defined: 2 loads, 1 store and 1 error → load_count=2, store_count=1, err_count=1. Reset mid-load → all counters return to 0 and no response pulse appears.
